// File: rtl/prog_loader.sv
// prog_loader
// Burst sequencer in front of prog_mux. A command names a target core, a
// first program address and a word count. The loader then streams
// instruction words into that core's program memory. Each accepted data
// word produces one registered write beat (we, sel, waddr, wdata).
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_core, cmd_addr, cmd_len payload
//                      (cmd_len counts words, 0..2**PC_WIDTH)
//   data_valid/ready   instruction word handshake; data payload
//   abort              synchronous cancel of the load in progress
//   we, sel, waddr,    registered write beat driven into prog_mux
//   wdata
//   busy               high while a load is in progress
//   done               one-cycle pulse when a load completes normally
//   csum               running XOR of the words written by the current load
//
// Configuration
//   PROG_LOADER_CSUM_EN  when defined, csum is a register. It is cleared on
//                        each command handshake and XORed with every accepted
//                        word. When undefined, csum is tied to zero.
module prog_loader #(
    parameter int CORES       = 4,
    parameter int LOG_CORES   = 2,
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LOG_CORES-1:0]   cmd_core,
    input  logic [PC_WIDTH-1:0]    cmd_addr,
    input  logic [PC_WIDTH:0]      cmd_len,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [INSTR_WIDTH-1:0] data,
    input  logic                   abort,
    output logic                   we,
    output logic [LOG_CORES-1:0]   sel,
    output logic [PC_WIDTH-1:0]    waddr,
    output logic [INSTR_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic [INSTR_WIDTH-1:0] csum
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // The core select must be wide enough to address every core.
    if ((64'd1 << LOG_CORES) < 64'(CORES)) begin : g_bad_log_cores
        $error("prog_loader: LOG_CORES too narrow for CORES");
    end

    state_t                 state_q, state_d;
    logic [LOG_CORES-1:0]   core_q, core_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [PC_WIDTH:0]      remaining_q, remaining_d;
    logic                   we_q, we_d;
    logic [LOG_CORES-1:0]   sel_q, sel_d;
    logic [PC_WIDTH-1:0]    waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   done_q, done_d;
`ifdef PROG_LOADER_CSUM_EN
    logic [INSTR_WIDTH-1:0] csum_q, csum_d;
`endif

    logic cmd_hs;
    logic data_hs;

    // When abort is high it blocks the data handshake, so a coincident beat is never written.
    assign cmd_ready  = (state_q == IDLE);
    assign data_ready = (state_q == LOAD) & ~abort;
    assign busy       = (state_q == LOAD);
    assign cmd_hs     = cmd_valid & cmd_ready;
    assign data_hs    = data_valid & data_ready;

    always_comb begin
        state_d     = state_q;
        core_d      = core_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        we_d        = 1'b0;
        sel_d       = sel_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    core_d      = cmd_core;
                    addr_d      = cmd_addr;
                    remaining_d = cmd_len;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d      = '0;
`endif
                    // A zero-length load completes at once, and no write is issued.
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (data_hs) begin
                    we_d        = 1'b1;
                    sel_d       = core_q;
                    waddr_d     = addr_q;
                    wdata_d     = data;
                    addr_d      = addr_q + PC_WIDTH'(1);
                    remaining_d = remaining_q - (PC_WIDTH+1)'(1);
`ifdef PROG_LOADER_CSUM_EN
                    csum_d      = csum_q ^ data;
`endif
                    if (remaining_q == (PC_WIDTH+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            core_q      <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_q      <= core_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    assign we    = we_q;
    assign sel   = sel_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign done  = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed testbench for prog_loader with CORES=4, PC_WIDTH=4 and INSTR_WIDTH=8.
// A table of per-cycle vectors covers the main load, gapped and wrapping
// loads, a zero-length load, abort, and a command offered while busy.
// Hand-written sequences cover the full 16-word load, the data_ready gating,
// and a reset asserted in the middle of a burst.
module tb_prog_loader;

    localparam int NUM_VECS = 22;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_core;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data;
    logic       abort;
    logic       we;
    logic [1:0] sel;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] csum;

    int checks;
    int failures;

    typedef struct {
        logic       cmd_valid;
        logic [1:0] cmd_core;
        logic [3:0] cmd_addr;
        logic [4:0] cmd_len;
        logic       data_valid;
        logic [7:0] data;
        logic       abort;
        logic       exp_we;
        logic [1:0] exp_sel;
        logic [3:0] exp_waddr;
        logic [7:0] exp_wdata;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_csum;
    } vec_t;

    vec_t vecs [NUM_VECS];

    prog_loader #(
        .CORES(4),
        .LOG_CORES(2),
        .PC_WIDTH(4),
        .INSTR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_core(cmd_core),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data(data),
        .abort(abort),
        .we(we),
        .sel(sel),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .csum(csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_valid  = v.cmd_valid;
        cmd_core   = v.cmd_core;
        cmd_addr   = v.cmd_addr;
        cmd_len    = v.cmd_len;
        data_valid = v.data_valid;
        data       = v.data;
        abort      = v.abort;
    endtask

    function automatic logic [7:0] exp_csum_of(input logic [7:0] c);
`ifdef PROG_LOADER_CSUM_EN
        return c;
`else
        return (c & 8'h00);
`endif
    endfunction

    task automatic idle_inputs();
        cmd_valid  = 1'b0;
        cmd_core   = 2'd0;
        cmd_addr   = 4'd0;
        cmd_len    = 5'd0;
        data_valid = 1'b0;
        data       = 8'd0;
        abort      = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //           cv    core  addr   len    dv    data    ab    we    sel   waddr  wdata   busy  done  csum
        vecs[0]  = '{1'b1, 2'd2, 4'd3,  5'd3,  1'b0, 8'd0,   1'b0, 1'b0, 2'd0, 4'd0,  8'd0,   1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd11,  1'b0, 1'b1, 2'd2, 4'd3,  8'd11,  1'b1, 1'b0, 8'd11};
        vecs[2]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd22,  1'b0, 1'b1, 2'd2, 4'd4,  8'd22,  1'b1, 1'b0, 8'd29};
        vecs[3]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd33,  1'b0, 1'b1, 2'd2, 4'd5,  8'd33,  1'b0, 1'b1, 8'h3C};
        vecs[4]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd99,  1'b0, 1'b0, 2'd2, 4'd5,  8'd33,  1'b0, 1'b0, 8'h3C};
        vecs[5]  = '{1'b1, 2'd1, 4'd14, 5'd4,  1'b0, 8'd0,   1'b0, 1'b0, 2'd2, 4'd5,  8'd33,  1'b1, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b0, 8'd7,   1'b0, 1'b0, 2'd2, 4'd5,  8'd33,  1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd1,   1'b0, 1'b1, 2'd1, 4'd14, 8'd1,   1'b1, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd2,   1'b0, 1'b1, 2'd1, 4'd15, 8'd2,   1'b1, 1'b0, 8'd3};
        vecs[9]  = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b0, 8'd9,   1'b0, 1'b0, 2'd1, 4'd15, 8'd2,   1'b1, 1'b0, 8'd3};
        vecs[10] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd3,   1'b0, 1'b1, 2'd1, 4'd0,  8'd3,   1'b1, 1'b0, 8'd0};
        vecs[11] = '{1'b1, 2'd3, 4'd7,  5'd2,  1'b0, 8'd0,   1'b0, 1'b0, 2'd1, 4'd0,  8'd3,   1'b1, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'd4,   1'b0, 1'b1, 2'd1, 4'd1,  8'd4,   1'b0, 1'b1, 8'd4};
        vecs[13] = '{1'b1, 2'd3, 4'd9,  5'd0,  1'b0, 8'd0,   1'b0, 1'b0, 2'd1, 4'd1,  8'd4,   1'b0, 1'b1, 8'd0};
        vecs[14] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b0, 8'd0,   1'b0, 1'b0, 2'd1, 4'd1,  8'd4,   1'b0, 1'b0, 8'd0};
        vecs[15] = '{1'b1, 2'd0, 4'd0,  5'd5,  1'b0, 8'd0,   1'b0, 1'b0, 2'd1, 4'd1,  8'd4,   1'b1, 1'b0, 8'd0};
        vecs[16] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'hA1,  1'b0, 1'b1, 2'd0, 4'd0,  8'hA1,  1'b1, 1'b0, 8'hA1};
        vecs[17] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'hB2,  1'b0, 1'b1, 2'd0, 4'd1,  8'hB2,  1'b1, 1'b0, 8'h13};
        vecs[18] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'hC3,  1'b1, 1'b0, 2'd0, 4'd1,  8'hB2,  1'b0, 1'b0, 8'h13};
        vecs[19] = '{1'b1, 2'd3, 4'd2,  5'd1,  1'b0, 8'd0,   1'b1, 1'b0, 2'd0, 4'd1,  8'hB2,  1'b1, 1'b0, 8'd0};
        vecs[20] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b1, 8'h5A,  1'b0, 1'b1, 2'd3, 4'd2,  8'h5A,  1'b0, 1'b1, 8'h5A};
        vecs[21] = '{1'b0, 2'd0, 4'd0,  5'd0,  1'b0, 8'd0,   1'b0, 1'b0, 2'd3, 4'd2,  8'h5A,  1'b0, 1'b0, 8'h5A};

        // Reset state, with a data word offered while the loader is idle.
        rst_n = 1'b0;
        idle_inputs();
        data_valid = 1'b1;
        #12;
        checkOutput("reset.we",         32'(we),         32'd0);
        checkOutput("reset.busy",       32'(busy),       32'd0);
        checkOutput("reset.done",       32'(done),       32'd0);
        checkOutput("reset.cmd_ready",  32'(cmd_ready),  32'd1);
        checkOutput("reset.data_ready", 32'(data_ready), 32'd0);
        checkOutput("reset.sel",        32'(sel),        32'd0);
        checkOutput("reset.waddr",      32'(waddr),      32'd0);
        checkOutput("reset.wdata",      32'(wdata),      32'd0);
        checkOutput("reset.csum",       32'(csum),       32'd0);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors. Outputs are checked 1 time unit after the edge on which each vector is applied.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.we", i),        32'(we),        32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d.sel", i),       32'(sel),       32'(vecs[i].exp_sel));
            checkOutput($sformatf("vec%0d.waddr", i),     32'(waddr),     32'(vecs[i].exp_waddr));
            checkOutput($sformatf("vec%0d.wdata", i),     32'(wdata),     32'(vecs[i].exp_wdata));
            checkOutput($sformatf("vec%0d.busy", i),      32'(busy),      32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d.cmd_ready", i), 32'(cmd_ready), 32'(!vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d.done", i),      32'(done),      32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d.csum", i),      32'(csum),
                        32'(exp_csum_of(vecs[i].exp_csum)));
        end
        idle_inputs();

        // Full 16-word load starting at address 5. Every address must be written exactly once.
        begin
            logic [15:0] mask;
            int writes;
            int dups;
            int dones;
            int bad_sel;
            int done_on_last;
            logic [7:0] x;
            mask = '0;
            writes = 0;
            dups = 0;
            dones = 0;
            bad_sel = 0;
            done_on_last = 0;
            x = 8'd0;
            cmd_valid = 1'b1;
            cmd_core  = 2'd1;
            cmd_addr  = 4'd5;
            cmd_len   = 5'd16;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            checkOutput("len16.busy_start", 32'(busy), 32'd1);
            abort = 1'b1;
            #1;
            checkOutput("len16.data_ready_abort", 32'(data_ready), 32'd0);
            abort = 1'b0;
            #1;
            checkOutput("len16.data_ready_load", 32'(data_ready), 32'd1);
            data_valid = 1'b1;
            for (int c = 0; c < 20; c++) begin
                data = 8'(c + 1);
                @(posedge clk);
                #1;
                if (we) begin
                    if (mask[waddr]) dups++;
                    mask[waddr] = 1'b1;
                    writes++;
                    x = x ^ wdata;
                    if (sel != 2'd1) bad_sel++;
                end
                if (done) begin
                    dones++;
                    if (we && writes == 16) done_on_last++;
                end
            end
            idle_inputs();
            checkOutput("len16.writes",       32'(writes),       32'd16);
            checkOutput("len16.mask",         32'(mask),         32'hFFFF);
            checkOutput("len16.dups",         32'(dups),         32'd0);
            checkOutput("len16.bad_sel",      32'(bad_sel),      32'd0);
            checkOutput("len16.dones",        32'(dones),        32'd1);
            checkOutput("len16.done_on_last", 32'(done_on_last), 32'd1);
            checkOutput("len16.busy_end",     32'(busy),         32'd0);
            // The words were 1..16, and their XOR is 16.
            checkOutput("len16.csum",         32'(csum),         32'(exp_csum_of(8'd16)));
        end

        // Reset asserted mid-burst. Outputs must clear without waiting for a clock edge.
        cmd_valid = 1'b1;
        cmd_core  = 2'd2;
        cmd_addr  = 4'd3;
        cmd_len   = 5'd8;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        data_valid = 1'b1;
        data       = 8'h77;
        @(posedge clk);
        #1;
        checkOutput("midrst.we_before", 32'(we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.we",         32'(we),         32'd0);
        checkOutput("midrst.busy",       32'(busy),       32'd0);
        checkOutput("midrst.cmd_ready",  32'(cmd_ready),  32'd1);
        checkOutput("midrst.data_ready", 32'(data_ready), 32'd0);
        checkOutput("midrst.sel",        32'(sel),        32'd0);
        checkOutput("midrst.waddr",      32'(waddr),      32'd0);
        checkOutput("midrst.wdata",      32'(wdata),      32'd0);
        checkOutput("midrst.done",       32'(done),       32'd0);
        checkOutput("midrst.csum",       32'(csum),       32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst.busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
